weight_bank: RTL
================

Name: weight_bank

Overview:
- Parametrised bank of NUM_W signed fixed-point trainable weights for the backpropagation datapath.
- Each weight can be preloaded with a common initial value, then updated one at a time by signed deltas arriving through a valid/ready stream.
- Sits between the delta-weight calculators and the forward/backward MAC units.
- All weights are exported as a flat bus, and a registered random-read port is provided.

Parameters:
- DATA_W, 16: weight/delta width, signed two's complement.
- FRAC_W, 10: fractional bits (default Q6.10).
- NUM_W, 4: number of weights (channels), at least 1.
- IDX_W, 3: width of the index ports; must satisfy 2**IDX_W > NUM_W so out-of-range indices are representable.
- INIT_VAL, 16'h0200: initial value for every weight (0.5 in Q6.10).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- init_start  in  1  one-cycle request to load INIT_VAL into all weights
- busy  out  1  high while the INIT sweep runs
- init_done  out  1  one-cycle pulse when the sweep completes
- upd_valid  in  1  update beat valid
- upd_ready  out  1  bank can accept an update beat
- upd_idx  in  IDX_W  target weight index
- upd_delta  in  DATA_W  signed delta added to the target weight
- upd_last  in  1  marks the final beat of an update batch
- upd_done  out  1  one-cycle pulse after the last beat is written
- err_idx  out  1  sticky flag: an out-of-range index was received
- rd_idx  in  IDX_W  read index
- rd_data  out  DATA_W  registered read data
- w_flat  out  DATA_W*NUM_W  all weights; w[k] occupies bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset, checked at every posedge:
  - all weights, rd_data, busy, init_done, upd_done and err_idx are 0; state is IDLE.
  - Reset overrides any in-flight INIT sweep or update.
- upd_ready = (state==IDLE) & ~init_start & ~reset. It is combinational and is 0 while reset is high.
- FSM states: IDLE, INIT.
  - IDLE to INIT when init_start=1. The counter cnt is cleared to 0 and busy is set.
  - In INIT, each cycle writes w[cnt] <= INIT_VAL and increments cnt.
  - When cnt==NUM_W-1 the FSM returns to IDLE, clears busy, and pulses init_done on that same edge.
  - Latency: busy is high for exactly NUM_W cycles; init_done is asserted in the NUM_W-th cycle after the start edge.
  - init_start is ignored in INIT. No update beats are accepted in INIT.
- Update beat (upd_valid & upd_ready at a posedge):
  - If upd_idx < NUM_W, w[upd_idx] <= w[upd_idx] + upd_delta on that edge; the sum is visible on w_flat the next cycle.
  - Back-to-back beats to the same index accumulate, because each beat reads the already-registered value.
  - If upd_idx >= NUM_W, no weight changes and err_idx <= 1. err_idx is cleared only by reset.
  - If upd_last=1 on an accepted beat, upd_done pulses on the same edge, even when the index was out of range.
- Simultaneous init_start and upd_valid in IDLE: INIT wins and the beat is not accepted (upd_ready=0).
- Arithmetic:
  - The sum is formed at DATA_W+1 bits.
  - Result handling depends on WEIGHT_BANK_SAT_EN (see Optional Feature).
  - No rounding: delta and weight share the same Q format.
- Read port: rd_data <= (rd_idx < NUM_W) ? w[rd_idx] : 0, one-cycle latency.
  - rd_data shows the pre-update value if a write to the same index occurs on the same edge.
- w_flat is driven directly from the weight registers.

Optional Feature:
- Macro: WEIGHT_BANK_SAT_EN.
- When defined: on overflow the sum clamps to the signed extremes (max 0x7FFF / min 0x8000 for DATA_W=16).
- When undefined: the sum wraps to DATA_W bits (legacy two's-complement behaviour).

Decomposition:
- Package nn_fixed_pkg:
  - DATA_W_DEF and FRAC_W_DEF constants;
  - Q6.10 helper constants: ONE=0x0400, HALF=0x0200, QMAX, QMIN;
  - state enum {IDLE, INIT}.
- Sub-module weight_sat_add: combinational DATA_W adder that honours WEIGHT_BANK_SAT_EN; reused by other weight and bias banks.

Test Plan (NUM_W=4, defaults):
1. Reset, then init_start for 1 cycle -> busy high 4 cycles, init_done single pulse on the 4th edge, w_flat=0x0200_0200_0200_0200, upd_ready low during busy.
2. After init, beat idx=2, delta=0x0100, last=1 -> w[2]=0x0300 next cycle, others 0x0200, upd_done one pulse. rd_idx=2 gives rd_data=0x0300 one cycle later.
3. Overflow, w[1]=0x7F00 plus delta 0x0200 -> with SAT_EN w[1]=0x7FFF; without it w[1]=0x8100.
4. Negative deltas:
   - w[0]=0x0200 plus 0xFE00 -> 0x0000.
   - w[3]=0x8100 plus 0x8000 -> 0x8000 (SAT_EN) / 0x0100 (wrap).
   - Back-to-back beats to idx 0 with deltas 0x0001 and 0x0002 -> +0x0003.
5. Beat idx=5, delta=0x0100, last=1 -> all weights unchanged, err_idx=1 and stays 1 until reset; upd_done still pulses; rd_idx=5 gives rd_data=0.
6. Boundary events:
   - Reset asserted in INIT cycle 2 -> next cycle all weights 0, busy=0, no init_done.
   - init_start and upd_valid in the same IDLE cycle -> upd_ready=0, beat not taken, INIT runs.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point constants and FSM state type for the weight and bias banks.
// Default format is Q6.10 on a 16-bit signed word.
package nn_fixed_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 10;

  localparam logic [DATA_W_DEF-1:0] ONE  = 16'h0400;
  localparam logic [DATA_W_DEF-1:0] HALF = 16'h0200;
  localparam logic [DATA_W_DEF-1:0] QMAX = 16'h7FFF;
  localparam logic [DATA_W_DEF-1:0] QMIN = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/weight_sat_add.sv
// Combinational signed weight + delta adder, shared by the weight and bias banks.
// WEIGHT_BANK_SAT_EN selects clamping on overflow; otherwise the sum wraps.
module weight_sat_add #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

`ifdef WEIGHT_BANK_SAT_EN
  logic [DATA_W:0] sum_ext;

  assign sum_ext = {a[DATA_W-1], a} + {b[DATA_W-1], b};

  // Overflow shows up as disagreement between the guard bit and the result sign.
  always_comb begin
    y = sum_ext[DATA_W-1:0];
    if (sum_ext[DATA_W] != sum_ext[DATA_W-1])
      y = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign y = a + b;
`endif

endmodule

// File: rtl/weight_bank.sv
// Bank of NUM_W signed fixed-point trainable weights: INIT sweep, streamed delta
// updates, flat export and a registered read port. Optional: WEIGHT_BANK_SAT_EN.
module weight_bank
  import nn_fixed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int NUM_W  = 4,
  parameter int IDX_W  = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1) << (FRAC_W - 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init_start,
  output logic                     busy,
  output logic                     init_done,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [IDX_W-1:0]         upd_idx,
  input  logic [DATA_W-1:0]        upd_delta,
  input  logic                     upd_last,
  output logic                     upd_done,
  output logic                     err_idx,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W*NUM_W-1:0]  w_flat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_W - 1);

  wb_state_e                      state;
  logic [IDX_W-1:0]               cnt;
  logic [NUM_W-1:0][DATA_W-1:0]   w;
  logic [NUM_W-1:0][DATA_W-1:0]   sum;
  logic                           upd_fire;
  logic                           idx_ok;
  logic                           rd_ok;
  logic [DATA_W-1:0]              rd_mux;

  assign upd_ready = (state == IDLE) & ~init_start & ~reset;
  assign upd_fire  = upd_valid & upd_ready;
  assign idx_ok    = int'(upd_idx) < NUM_W;
  assign rd_ok     = int'(rd_idx) < NUM_W;
  assign w_flat    = w;

  // Each lane adds the broadcast delta to its own registered value, so
  // back-to-back beats to the same lane accumulate naturally.
  for (genvar k = 0; k < NUM_W; k++) begin : g_lane
    logic              hit_init;
    logic              hit_upd;
    logic [DATA_W-1:0] w_q;

    assign hit_init = (state == INIT) && (cnt == IDX_W'(k));
    assign hit_upd  = upd_fire && (upd_idx == IDX_W'(k));
    assign w[k]     = w_q;

    weight_sat_add #(.DATA_W(DATA_W)) u_add (
      .a (w_q),
      .b (upd_delta),
      .y (sum[k])
    );

    always_ff @(posedge clk) begin
      if (reset)         w_q <= '0;
      else if (hit_init) w_q <= INIT_VAL;
      else if (hit_upd)  w_q <= sum[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      upd_done  <= 1'b0;
      err_idx   <= 1'b0;
    end else begin
      init_done <= 1'b0;
      upd_done  <= upd_fire & upd_last;
      if (upd_fire && !idx_ok) err_idx <= 1'b1;
      case (state)
        IDLE: begin
          if (init_start) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_W; k++)
      if (rd_idx == IDX_W'(k)) rd_mux = w[k];
  end

  // Read samples the pre-edge weights, so a same-edge write is not visible yet.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_ok ? rd_mux : '0;
  end

endmodule
